// File: rtl/cmd_issuer.sv
// Command issuer: accepts one upstream command, streams LD/LD/INFO words to the
// processor under an ack handshake, then times the run phase and reports completion.
module cmd_issuer #(
  parameter int              CNT_W       = 16,
  parameter int              RUN_TIMEOUT = 1024,
  parameter int              ADDR_W      = 16,
  parameter int              INFO_W      = 16,
  parameter int              ID_W        = 4,
  parameter int              OP_W        = 4,
  parameter logic [OP_W-1:0] INSTR_LD    = OP_W'(1),
  parameter logic [OP_W-1:0] INSTR_INFO  = OP_W'(2),
  localparam int             PAY_W       = (ADDR_W > INFO_W) ? ADDR_W : INFO_W,
  localparam int             INSTR_W     = OP_W + PAY_W
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [ADDR_W-1:0]  i_cmd_addr0,
  input  logic [ADDR_W-1:0]  i_cmd_addr1,
  input  logic [INFO_W-1:0]  i_cmd_info,
  input  logic [ID_W-1:0]    i_cmd_id,
  output logic               o_en,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  input  logic               i_ack,
  input  logic               i_finish,
  input  logic               i_busy,
  output logic               o_done,
  output logic [ID_W-1:0]    o_done_id,
  output logic [CNT_W-1:0]   o_run_cycles,
  output logic               o_timeout,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    IDLE, START, SEND, WAIT_ACK, WAIT_LOW, RUN, RELEASE
  } state_t;

  localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W+1)'(RUN_TIMEOUT);

  state_t             state;
  logic [1:0]         k;
  logic [ADDR_W-1:0]  addr0_q;
  logic [ADDR_W-1:0]  addr1_q;
  logic [INFO_W-1:0]  info_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   run_cnt;
  logic [CNT_W-1:0]   run_cnt_nxt;
  logic               timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [INSTR_W-1:0] word_for(input logic [1:0]        idx,
                                                  input logic [ADDR_W-1:0] a0,
                                                  input logic [ADDR_W-1:0] a1,
                                                  input logic [INFO_W-1:0] inf);
    logic [INSTR_W-1:0] w;
    case (idx)
      2'd0:    w = {INSTR_LD, PAY_W'(a0)};
      2'd1:    w = {INSTR_LD, PAY_W'(a1)};
      default: w = {INSTR_INFO, PAY_W'(inf)};
    endcase
    return w;
  endfunction

  assign run_cnt_nxt = sat_inc(run_cnt);
  // Zero-extend so a RUN_TIMEOUT beyond the counter range can never match.
  assign timeout_hit = ({1'b0, run_cnt_nxt} == TIMEOUT_VAL);
  assign o_cmd_ready = (state == IDLE) && !i_busy;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      k            <= 2'd0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      info_q       <= '0;
      id_q         <= '0;
      run_cnt      <= '0;
      o_en         <= 1'b0;
      o_valid      <= 1'b0;
      o_instr      <= '0;
      o_done       <= 1'b0;
      o_done_id    <= '0;
      o_run_cycles <= '0;
      o_timeout    <= 1'b0;
    end else begin
      // Strobes default low so each fires for exactly the cycle of its state.
      o_en      <= 1'b0;
      o_valid   <= 1'b0;
      o_instr   <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid && !i_busy) begin
            addr0_q <= i_cmd_addr0;
            addr1_q <= i_cmd_addr1;
            info_q  <= i_cmd_info;
            id_q    <= i_cmd_id;
            run_cnt <= '0;
            o_en    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          k       <= 2'd0;
          o_valid <= 1'b1;
          o_instr <= word_for(2'd0, addr0_q, addr1_q, info_q);
          state   <= SEND;
        end
        SEND: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_ack) state <= (k == 2'd2) ? RUN : WAIT_LOW;
        end
        WAIT_LOW: begin
          // Wait for ack to drop so one ack pulse never covers two words.
          if (!i_ack) begin
            k       <= k + 2'd1;
            o_valid <= 1'b1;
            o_instr <= word_for(k + 2'd1, addr0_q, addr1_q, info_q);
            state   <= SEND;
          end
        end
        RUN: begin
          run_cnt   <= run_cnt_nxt;
          o_timeout <= timeout_hit;
          if (i_finish) begin
            o_valid      <= 1'b1;
            o_done       <= 1'b1;
            o_done_id    <= id_q;
            o_run_cycles <= run_cnt_nxt;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the run-cycle counter.
REQ-002 Parameter RUN_TIMEOUT, default 1024, sets the RUN-state cycle count at which o_timeout fires.
REQ-003 i_clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 i_rstn  in  1  asynchronous active-low reset.
REQ-005 i_cmd_valid  in  1  an upstream command is present.
REQ-006 o_cmd_ready  out  1  issuer accepts the command this cycle.
REQ-007 i_cmd_addr0, i_cmd_addr1  in  addr_t  operand base addresses.
REQ-008 i_cmd_info  in  instr_info_t  op/count descriptor.
REQ-009 i_cmd_id  in  cmd_id_t  scoreboard tag.
REQ-010 o_en  out  1  wakes the processor from idle.
REQ-011 o_valid  out  1  o_instr is valid; also the release strobe in the finish phase.
REQ-012 o_instr  out  instr_t  instruction word to the processor.
REQ-013 i_ack  in  1  processor acknowledge.
REQ-014 i_finish  in  1  processor has completed its command.
REQ-015 i_busy  in  1  processor is not idle.
REQ-016 o_done  out  1  one-cycle completion pulse, used for the scoreboard flush.
REQ-017 o_done_id  out  cmd_id_t  tag of the completed command.
REQ-018 o_run_cycles  out  CNT_W  cycles spent in RUN for the completed command.
REQ-019 o_timeout  out  1  one-cycle watchdog pulse.
REQ-020 o_busy  out  1  issuer is not in IDLE.

Function
REQ-021 States: IDLE, START, SEND, WAIT_ACK, WAIT_LOW, RUN, RELEASE; a 2-bit word index k (0=LD addr0, 1=LD addr1, 2=INFO).
REQ-022 IDLE: o_cmd_ready = !i_busy; when i_cmd_valid && o_cmd_ready, latch addr0/addr1/info/id, clear the run counter, and go to START.
REQ-023 START: o_en=1 for exactly one cycle; set k=0; go to SEND.
REQ-024 SEND: o_valid=1 for exactly one cycle (never two consecutive cycles for the same word); o_instr = {INSTR_LD, addr0} for k=0, {INSTR_LD, addr1} for k=1, {INSTR_INFO, info} for k=2; go to WAIT_ACK.
REQ-025 WAIT_ACK: o_valid=0; on i_ack=1, go to RUN if k=2, else go to WAIT_LOW.
REQ-026 WAIT_LOW: o_valid=0; on i_ack=0, increment k and go to SEND; i_ack remaining high stalls indefinitely.
REQ-027 RUN: o_valid=0; the run counter increments every cycle and saturates at all-ones; on i_finish=1, go to RELEASE.
REQ-028 RUN: o_timeout pulses for one cycle when the counter equals RUN_TIMEOUT; the state does not change and waiting continues.
REQ-029 RELEASE: o_valid=1 for one cycle with o_instr all-zero; o_done=1 for one cycle; o_done_id = latched id; o_run_cycles = counter value; return to IDLE.
REQ-030 o_done_id and o_run_cycles hold their value until the next RELEASE.
REQ-031 o_instr is all-zero in every state except SEND.
REQ-032 o_busy = (state != IDLE).
REQ-033 i_cmd_* is ignored outside IDLE; a command presented while i_busy=1 is held off with o_cmd_ready=0.
REQ-034 i_finish asserted before RUN is ignored.
REQ-035 An i_ack arriving in a state where it is not expected has no effect.
REQ-036 Latency from command accept to the first o_valid is exactly 2 cycles.

Reset
REQ-037 While i_rstn=0, state=IDLE, k=0, and the counter and latched fields are zero.
REQ-038 While i_rstn=0, o_en, o_valid, o_done, o_timeout and o_busy are 0, and o_instr, o_done_id and o_run_cycles are zero.
REQ-039 Reset asserted mid-command aborts the command with no o_done.
REQ-040 After reset release, o_cmd_ready rises in the first cycle in which i_busy=0.

Verification
REQ-041 Nominal: cmd addr0=0x000, addr1=0x400, count=8, id=3; processor model acks one cycle after each o_valid and finishes after 10 RUN cycles -> o_instr sequence LD 0x000, LD 0x400, INFO; one RELEASE valid; o_done with id=3 and o_run_cycles=10.
REQ-042 Ack held high 3 extra cycles after the first LD -> the second LD is not sent until i_ack falls; exactly three o_valid pulses precede RUN.
REQ-043 i_busy=1 with i_cmd_valid=1 -> o_cmd_ready=0 and no o_en until i_busy falls.
REQ-044 RUN_TIMEOUT=5, finish after 8 RUN cycles -> o_timeout pulses once; o_done fires with o_run_cycles=8.
REQ-045 Reset asserted in WAIT_ACK for k=1 -> all outputs zero immediately; no o_done; the next command starts cleanly with k=0.
REQ-046 Back-to-back commands A then B -> B is accepted no earlier than the cycle after A's RELEASE; o_done_id shows A then B.
